// File: rtl/score_pkg.sv
// Shared types and defaults for the score event scheduler.
// Holds the issue-state enum, score-code type, requester count and popcount helper.
package score_pkg;

  localparam int NUM_REQ   = 4;
  localparam int DEPTH_DEF = 4;
  localparam int GAP_DEF   = 2;

  typedef logic [1:0] code_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } issue_t;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/score_fifo.sv
// Small synchronous FIFO holding granted score codes in grant order.
// Ports: clk, reset, clear, push, pop, din, dout, full, empty, count.
module score_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/score_event_scheduler.sv
// Latches score hits from four requesters, arbitrates round-robin into a FIFO
// and issues spaced one-hot score pulses. Ports: clk, reset, clear, hit_valid,
// hit_value, score1..score4, pending_cnt, busy, dropped.
module score_event_scheduler
  import score_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int GAP   = GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [3:0] hit_valid,
  input  logic [7:0] hit_value,
  output logic       score1,
  output logic       score2,
  output logic       score3,
  output logic       score4,
  output logic [3:0] pending_cnt,
  output logic       busy,
  output logic       dropped
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_REQ-1:0] lat_v;
  logic [NUM_REQ-1:0] lat_v_n;
  code_t              lat_c [NUM_REQ];
  logic [1:0]         rr;
  logic [1:0]         idx;
  logic               gnt_v;
  logic [1:0]         gnt_id;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               drop_hit;

  issue_t             state;
  logic [2:0]         gcnt;
  logic [3:0]         pulse;

  logic               push;
  logic               pop;
  code_t              din;
  code_t              dout;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic [CW-1:0]      cnt_n;
  logic [3:0]         pend_n;
  logic               idle_n;

  // Round-robin search starting at rr; only one grant per edge.
  always_comb begin
    idx    = '0;
    gnt_v  = 1'b0;
    gnt_id = rr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr + 2'(k);
      if (!gnt_v && lat_v[idx] && !full) begin
        gnt_v  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  assign gnt_oh = gnt_v ? (4'(1) << gnt_id) : '0;
  assign push   = gnt_v;
  assign din    = lat_c[gnt_id];
  assign pop    = (state == S_IDLE) && !empty;

  // A granted latch frees this edge, so a simultaneous hit refills it.
  always_comb begin
    lat_v_n  = lat_v;
    drop_hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        lat_v_n[i] = hit_valid[i];
      end else begin
        lat_v_n[i] = lat_v[i] | hit_valid[i];
        if (hit_valid[i] && lat_v[i]) drop_hit = 1'b1;
      end
    end
  end

  assign cnt_n  = count + CW'(push) - CW'(pop);
  assign pend_n = 4'(pop4(lat_v_n)) + 4'(cnt_n);
  assign idle_n = ((state == S_IDLE) && empty) ||
                  ((state == S_GAP) && (gcnt == '0));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lat_v   <= '0;
      rr      <= '0;
      dropped <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) lat_c[i] <= '0;
    end else begin
      lat_v <= lat_v_n;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hit_valid[i] && (gnt_oh[i] || !lat_v[i]))
          lat_c[i] <= hit_value[2*i +: 2];
      end
      if (gnt_v)    rr      <= gnt_id + 2'd1;
      if (drop_hit) dropped <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state       <= S_IDLE;
      gcnt        <= '0;
      pulse       <= '0;
      pending_cnt <= '0;
      busy        <= 1'b0;
    end else begin
      pending_cnt <= pend_n;
      busy        <= (pend_n != '0) || !idle_n;
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            pulse <= 4'(1) << dout;
            state <= S_PULSE;
          end
        end
        S_PULSE: begin
          pulse <= '0;
          gcnt  <= 3'(GAP - 1);
          state <= S_GAP;
        end
        S_GAP: begin
          if (gcnt == '0) state <= S_IDLE;
          else            gcnt  <= gcnt - 3'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign score1 = pulse[0];
  assign score2 = pulse[1];
  assign score3 = pulse[2];
  assign score4 = pulse[3];

  score_fifo #(
    .DEPTH (DEPTH),
    .W     (2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_score_event_scheduler.sv
// Scoreboard bench for score_event_scheduler (DEPTH=4, GAP=2).
// Expected pulse values are queued at stimulus time and popped by a monitor.
module tb_score_event_scheduler;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [3:0] hit_valid;
  logic [7:0] hit_value;
  logic       score1, score2, score3, score4;
  logic [3:0] pending_cnt;
  logic       busy;
  logic       dropped;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pts      = 0;
  int exp_q[$];
  int ptimes[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  score_event_scheduler #(.DEPTH(4), .GAP(GAP)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .hit_valid   (hit_valid),
    .hit_value   (hit_value),
    .score1      (score1),
    .score2      (score2),
    .score3      (score3),
    .score4      (score4),
    .pending_cnt (pending_cnt),
    .busy        (busy),
    .dropped     (dropped)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int n;
    int e;
    n = int'(score1) + int'(score2) + int'(score3) + int'(score4);
    if (n > 1) check("onehot", n, 1);
    else if (n == 1) begin
      e = score1 ? 1 : score2 ? 2 : score3 ? 3 : 4;
      pts += e;
      ptimes.push_back(cyc);
      if (exp_q.size() == 0) check("spurious", e, 0);
      else check("order", e, exp_q.pop_front());
    end
  end

  task automatic nxt(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 300) begin
      nxt();
      t++;
    end
    if (t >= 300) check("drain_timeout", t, 0);
    nxt(2);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    nxt();
    clear = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] v;
    int r, c, esum;
    reset = 1'b1; clear = 1'b0; hit_valid = '0; hit_value = '0;
    nxt(3);
    reset = 1'b0;
    check("rst_score", int'({score4, score3, score2, score1}), 0);
    check("rst_pend", pending_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", dropped, 0);

    // single hit: req0 code 2 -> score3 after E2
    exp_q.push_back(3);
    hit_valid = 4'b0001; hit_value = 8'h02;
    nxt();                         // after E0
    hit_valid = '0;
    check("single_pend_e0", pending_cnt, 1);
    nxt(2);                        // after E2
    check("single_lat", score3, 1);
    nxt();                         // after E3
    check("single_width", score3, 0);
    nxt();
    check("single_busy_gap", busy, 1);
    nxt();                         // after E5
    check("single_idle", busy, 0);
    drain();

    // simultaneous hits, rr reset to 0
    do_clear();
    ptimes.delete();
    exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(4);
    hit_valid = 4'b1111; hit_value = 8'hE4;
    nxt();
    hit_valid = '0;
    drain();
    check("sim_count", ptimes.size(), 4);
    if (ptimes.size() == 4)
      for (int i = 1; i < 4; i++)
        check("sim_space", ptimes[i] - ptimes[i-1], GAP + 2);

    // drop: fill FIFO from req0, then two req1 hits
    do_clear();
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(4); exp_q.push_back(1); exp_q.push_back(2);
    for (int k = 0; k < 5; k++) begin
      hit_valid = 4'b0001;
      hit_value = 8'(k % 4);
      nxt();
    end
    hit_valid = 4'b0010; hit_value = 8'h04;
    nxt();                         // after E5
    check("drop_pend_sat", pending_cnt, 5);
    check("drop_not_yet", dropped, 0);
    hit_value = 8'h0C;
    nxt();                         // after E6
    hit_valid = '0;
    check("drop_flag", dropped, 1);
    drain();
    check("drop_sticky", dropped, 1);

    // fairness: req0 and req3 hit every cycle
    do_clear();
    for (int k = 0; k < 5; k++) exp_q.push_back((k % 2 == 0) ? 1 : 4);
    hit_valid = 4'b1001; hit_value = 8'hC0;
    nxt(4);
    hit_valid = '0;
    drain();
    check("fair_drop", dropped, 1);

    // clear during GAP with 3 queued; rr now 1 so req1 issues first
    exp_q.push_back(2);
    hit_valid = 4'b1111; hit_value = 8'hE4;
    nxt();                         // after E0
    hit_valid = '0;
    nxt(4);                        // after E4
    check("clr_pend_pre", pending_cnt, 3);
    check("clr_busy_pre", busy, 1);
    clear = 1'b1; hit_valid = 4'b1111;
    nxt();                         // after E5
    clear = 1'b0; hit_valid = '0;
    exp_q.delete();
    check("clr_pend", pending_cnt, 0);
    check("clr_busy", busy, 0);
    check("clr_drop", dropped, 0);
    nxt(20);

    // reset+clear at the pop edge: no pulse follows
    hit_valid = 4'b0100; hit_value = 8'h10;
    nxt();                         // after E0
    hit_valid = '0;
    nxt();                         // after E1
    reset = 1'b1; clear = 1'b1;
    nxt();                         // after E2
    reset = 1'b0; clear = 1'b0;
    check("rst_mid_score", int'({score4, score3, score2, score1}), 0);
    check("rst_mid_pend", pending_cnt, 0);
    check("rst_mid_busy", busy, 0);
    nxt(12);

    // random sum check
    do_clear();
    pts = 0; esum = 0;
    for (int k = 0; k < 100; k++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      v = 8'(c) << (2 * r);
      hit_valid = 4'(1) << r;
      hit_value = v;
      exp_q.push_back(c + 1);
      esum += c + 1;
      nxt();
      hit_valid = '0;
      nxt($urandom_range(3, 4));
    end
    drain();
    check("sum_points", pts, esum);
    check("sum_nodrop", dropped, 0);
    check("sum_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_event_scheduler.md
SCORE_EVENT_SCHEDULER -- requirements
Module: score_event_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: score FIFO depth in entries; power of two, 2 to 8.
REQ-002 Parameter GAP, default 2: minimum idle cycles between consecutive score pulses; 1 to 7.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clear  input  1  game-restart flush; synchronous, active-high.
REQ-006 hit_valid  input  4  one bit per requester (player shot, shield, bonus ship, wave bonus); sampled every posedge.
REQ-007 hit_value  input  8  2-bit code per requester, bits [2i+1:2i] for requester i; code c means c+1 points.
REQ-008 score1, score2, score3, score4  output  1 each  one-cycle, mutually exclusive pulses to the BCD score counter; scoreN adds N points.
REQ-009 pending_cnt  output  4  number of events held (latched requests plus FIFO entries), 0 to 4+DEPTH.
REQ-010 busy  output  1  high when pending_cnt != 0 or the issue FSM is not IDLE.
REQ-011 dropped  output  1  sticky flag: at least one hit was lost since the last reset or clear.

Function
REQ-012 Each requester has a 1-deep pending latch (valid plus 2-bit code); hit_valid[i] sampled at edge E0 sets latch i at E0.
REQ-013 A hit on a requester whose latch is full and not granted at the same edge is discarded; the existing latch is kept and dropped is set.
REQ-014 When latch i is granted and hit_valid[i] is high at the same edge, latch i is reloaded with the new code; no drop occurs.
REQ-015 Arbiter: round-robin over the four latches, starting at pointer rr; at most one grant per edge; grant only when FIFO count < DEPTH.
REQ-016 After a grant to requester g, rr becomes (g+1) mod 4; rr is unchanged when there is no grant.
REQ-017 A granted latch is written to the FIFO tail at the grant edge (E1, the edge after E0 at the earliest); there is no bypass around a full FIFO.
REQ-018 Issue FSM states: IDLE, PULSE, GAP.
REQ-019 IDLE -> PULSE when the FIFO is non-empty: pop the head, register the one-hot pulse scoreN with N = code+1.
REQ-020 PULSE lasts exactly one cycle, then -> GAP.
REQ-021 GAP holds all score outputs low for exactly GAP cycles, then -> IDLE.
REQ-022 Minimum latency: hit sampled at E0 -> FIFO write at E1 -> pulse high in the cycle following E2 (3 cycles).
REQ-023 Sustained throughput: one pulse per GAP+2 cycles.
REQ-024 A FIFO push and pop at the same edge are both honoured; the count is unchanged.
REQ-025 FIFO pointers wrap modulo DEPTH.
REQ-026 The FIFO is first-in first-out: pulses appear in grant order.
REQ-027 score1..score4 are registered outputs; at most one is high in any cycle.
REQ-028 clear at an edge: empty all latches and the FIFO, FSM -> IDLE, all score outputs low, rr = 0, dropped = 0.
REQ-029 clear also discards any hit_valid sampled at the same edge.
REQ-030 pending_cnt and busy are registered and reflect the post-edge state.

Reset
REQ-031 reset has the same effect as clear: score1..score4 = 0, pending_cnt = 0, busy = 0, dropped = 0, FSM = IDLE, rr = 0, latches empty, FIFO empty.
REQ-032 When reset and clear are both asserted, reset has priority; the result is identical.
REQ-033 Assertion of reset mid-PULSE or mid-GAP takes effect at that edge; no pulse is emitted in the following cycle.

Structure
REQ-034 Shared package score_pkg holds the issue-state enumeration, the 2-bit score-code type, NUM_REQ = 4, and the DEPTH and GAP defaults.
REQ-035 The FIFO is a sub-module score_fifo (parameters DEPTH and width 2; ports push, pop, din, dout, full, empty, count); the arbiter and FSM stay in the top module.

Verification
REQ-036 Single hit: requester 0, code 2 at E0 -> score3 high for exactly one cycle after E2; busy returns to 0 after GAP cycles.
REQ-037 Simultaneous hits: all four requesters at once with codes 0,1,2,3 and rr = 0 -> pulses score1, score2, score3, score4 in that order, spaced GAP+2 = 4 cycles apart.
REQ-038 Drop: requester 1 hits on two consecutive edges while the FIFO is full (DEPTH = 4 filled) -> second hit lost, dropped = 1, pending_cnt saturates at 5.
REQ-039 Fairness: requesters 0 and 3 hit every cycle -> grants alternate 0,3,0,3; no starvation.
REQ-040 Reset/clear mid-operation: assert clear during GAP with 3 FIFO entries queued -> no further pulses; pending_cnt = 0, dropped = 0 at the next cycle.
REQ-041 Sum check: 100 random hits with no drops -> total points issued (sum of N over all pulses) equals the sum of (code+1) over all hits.
